// File: rtl/tcl_pkg.sv
// Shared encodings and default sizes for the transaction-layer egress merge.
package tcl_pkg;

    localparam int TCL_DATA_W = 12;
    localparam int TCL_DEPTH  = 4;
    localparam int TCL_OCC_W  = 3;
    localparam int TCL_CNT_W  = 5;

    localparam logic [2:0] IDX_TOTAL = 3'd4;

    typedef enum logic [3:0] {
        ST_ERROR  = 4'b0000,
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_t;

endpackage

// File: rtl/egress_lane_fifo.sv
// Single egress lane FIFO with occupancy count and overflow indication.
module egress_lane_fifo
    import tcl_pkg::*;
#(
    parameter int DATA_W = TCL_DATA_W,
    parameter int DEPTH  = TCL_DEPTH,
    parameter int OCC_W  = TCL_OCC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [OCC_W-1:0]  occ,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    // A pop frees the slot the same cycle, so a push at full is still legal then.
    assign full     = (occ == OCC_W'(DEPTH));
    assign do_pop   = pop && (occ != '0);
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign dout     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/tcl_egress_merge.sv
// Merges four lane FIFOs into one tagged egress stream with round-robin
// arbitration, control FSM, grant counters and a counter read port.
module tcl_egress_merge
    import tcl_pkg::*;
#(
    parameter int DATA_W = TCL_DATA_W,
    parameter int DEPTH  = TCL_DEPTH,
    parameter int OCC_W  = TCL_OCC_W,
    parameter int CNT_W  = TCL_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [OCC_W-1:0]  Umbral_alto,
    input  logic              push0,
    input  logic              push1,
    input  logic              push2,
    input  logic              push3,
    input  logic [DATA_W-1:0] dataIn0,
    input  logic [DATA_W-1:0] dataIn1,
    input  logic [DATA_W-1:0] dataIn2,
    input  logic [DATA_W-1:0] dataIn3,
    output logic              almost_full0,
    output logic              almost_full1,
    output logic              almost_full2,
    output logic              almost_full3,
    input  logic              stall,
    output logic [DATA_W-1:0] dataOut,
    output logic [1:0]        portOut,
    output logic              validOut,
    input  logic [2:0]        idx,
    input  logic              req,
    output logic [CNT_W-1:0]  counterOut,
    output logic              counterValid,
    output logic [3:0]        State,
    output logic              error
);

    state_t            state, state_nx;
    logic [OCC_W-1:0]  thr;
    logic [3:0]        push_v, push_eff, pop, ovf, non_empty, af;
    logic [DATA_W-1:0] din  [4];
    logic [DATA_W-1:0] head [4];
    logic [OCC_W-1:0]  occ  [4];
    logic [1:0]        last_grant, grant_lane;
    logic              grant_vld, out_load;
    logic [CNT_W-1:0]  lane_cnt [4];
    logic [CNT_W-1:0]  total_cnt, cnt_sel;
    logic [DATA_W-1:0] dout_p1;
    logic [1:0]        port_p1;
    logic              vld_p1;

    // Zero or out-of-range thresholds fall back to the full depth.
    function automatic logic [OCC_W-1:0] sat_thr(input logic [OCC_W-1:0] u);
        if (u == '0 || int'(u) > DEPTH) return OCC_W'(DEPTH);
        return u;
    endfunction

    assign push_v   = {push3, push2, push1, push0};
    assign din[0]   = dataIn0;
    assign din[1]   = dataIn1;
    assign din[2]   = dataIn2;
    assign din[3]   = dataIn3;
    assign push_eff = (state == ST_RESET || state == ST_INIT) ? 4'b0000 : push_v;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        egress_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OCC_W(OCC_W)) u_fifo (
            .clk      (clk),
            .rst_n    (reset),
            .push     (push_eff[k]),
            .pop      (pop[k]),
            .din      (din[k]),
            .dout     (head[k]),
            .occ      (occ[k]),
            .overflow (ovf[k])
        );
        assign non_empty[k] = (occ[k] != '0);
        assign af[k]        = (state == ST_INIT) || (occ[k] >= thr);
        assign pop[k]       = grant_vld && (grant_lane == 2'(k));
    end

    assign {almost_full3, almost_full2, almost_full1, almost_full0} = af;

    // Round-robin search starts just after the last granted lane.
    always_comb begin
        grant_vld  = 1'b0;
        grant_lane = 2'd0;
        if (state == ST_ACTIVE && !stall) begin
            for (int i = 1; i <= 4; i++) begin
                if (!grant_vld && non_empty[last_grant + 2'(i)]) begin
                    grant_vld  = 1'b1;
                    grant_lane = last_grant + 2'(i);
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RESET:  state_nx = ST_INIT;
            ST_INIT:   if (!init) state_nx = ST_IDLE;
            ST_IDLE:   if (init) state_nx = ST_INIT;
                       else if (|non_empty) state_nx = ST_ACTIVE;
            ST_ACTIVE: if (!(|non_empty) && !grant_vld) state_nx = ST_IDLE;
            default:   state_nx = ST_ERROR;
        endcase
        if (|ovf && state != ST_RESET) state_nx = ST_ERROR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_RESET;
            thr        <= OCC_W'(DEPTH);
            last_grant <= 2'd3;
            error      <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_INIT) thr <= sat_thr(Umbral_alto);
            if (grant_vld) last_grant <= grant_lane;
            if (|ovf) error <= 1'b1;
        end
    end

    // Stage p1: registered egress word, presented the cycle after its grant.
    assign out_load = grant_vld && (state_nx != ST_ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_p1 <= '0;
            port_p1 <= 2'd0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= out_load;
            if (out_load) begin
                dout_p1 <= head[grant_lane];
                port_p1 <= grant_lane;
            end
        end
    end

    assign dataOut  = dout_p1;
    assign portOut  = port_p1;
    assign validOut = vld_p1;
    assign State    = state;

    assign cnt_sel = (idx == IDX_TOTAL) ? total_cnt : lane_cnt[idx[1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) lane_cnt[k] <= '0;
            total_cnt    <= '0;
            counterOut   <= '0;
            counterValid <= 1'b0;
        end else begin
            if (grant_vld) begin
                lane_cnt[grant_lane] <= lane_cnt[grant_lane] + CNT_W'(1);
                total_cnt            <= total_cnt + CNT_W'(1);
            end
            counterValid <= 1'b0;
            if (req && state != ST_RESET) begin
                if (idx <= IDX_TOTAL) begin
                    counterOut   <= cnt_sel;
                    counterValid <= 1'b1;
                end else begin
                    counterOut <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tcl_egress_merge.sv
// Scoreboard bench for tcl_egress_merge: directed pushes with hand-computed egress order.
module tb_tcl_egress_merge;
    import tcl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init = 1'b0;
    logic        stall = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  Umbral_alto = 3'd0;
    logic [2:0]  idx = 3'd0;
    logic        push_v [4];
    logic [11:0] din_v  [4];
    logic        almost_full0, almost_full1, almost_full2, almost_full3;
    logic [11:0] dataOut;
    logic [1:0]  portOut;
    logic        validOut;
    logic [4:0]  counterOut;
    logic        counterValid;
    logic [3:0]  State;
    logic        error;
    logic [3:0]  af;

    int          tests = 0;
    int          fails = 0;
    logic [13:0] sb [$];
    logic [13:0] exp_w;

    assign af = {almost_full3, almost_full2, almost_full1, almost_full0};

    tcl_egress_merge dut (
        .clk(clk), .reset(reset), .init(init), .Umbral_alto(Umbral_alto),
        .push0(push_v[0]), .push1(push_v[1]), .push2(push_v[2]), .push3(push_v[3]),
        .dataIn0(din_v[0]), .dataIn1(din_v[1]), .dataIn2(din_v[2]), .dataIn3(din_v[3]),
        .almost_full0(almost_full0), .almost_full1(almost_full1),
        .almost_full2(almost_full2), .almost_full3(almost_full3),
        .stall(stall), .dataOut(dataOut), .portOut(portOut), .validOut(validOut),
        .idx(idx), .req(req), .counterOut(counterOut), .counterValid(counterValid),
        .State(State), .error(error)
    );

    always #5 clk = ~clk;

    // Monitor: every presented word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (validOut) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL egress_unexpected: got port=%0d data=%h, want no output", portOut, dataOut);
            end else begin
                exp_w = sb.pop_front();
                if ({portOut, dataOut} !== exp_w) begin
                    fails++;
                    $display("FAIL egress_word: got port=%0d data=%h, want port=%0d data=%h",
                             portOut, dataOut, exp_w[13:12], exp_w[11:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int lane, input logic [11:0] d, input bit exp_out);
        push_v[lane] = 1'b1;
        din_v[lane]  = d;
        if (exp_out) sb.push_back({2'(lane), d});
        tick();
        push_v[lane] = 1'b0;
    endtask

    task automatic drain(input bit chk_idle);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d words pending, want 0", sb.size());
        end
        if (chk_idle) begin
            tick();
            tick();
            chk("idle_after_drain", 32'(State), 32'(ST_IDLE));
        end
    endtask

    task automatic rd(input logic [2:0] i, input logic [4:0] want, input logic want_v, input string name);
        idx = i;
        req = 1'b1;
        tick();
        chk({name, "_valid"}, 32'(counterValid), 32'(want_v));
        chk(name, 32'(counterOut), 32'(want));
        req = 1'b0;
    endtask

    task automatic do_reset_init(input bit chk_on, input logic [2:0] u);
        reset       = 1'b0;
        init        = 1'b1;
        Umbral_alto = u;
        stall       = 1'b0;
        req         = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        if (chk_on) begin
            chk("state_init", 32'(State), 32'(ST_INIT));
            chk("af_in_init", 32'(af), 32'hF);
        end
        tick();
        init = 1'b0;
        tick();
        if (chk_on) begin
            chk("state_idle", 32'(State), 32'(ST_IDLE));
            chk("af_in_idle", 32'(af), 32'h0);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            push_v[k] = 1'b0;
            din_v[k]  = '0;
        end
        #2 reset = 1'b0;
        #2;
        chk("rst_state", 32'(State), 32'(ST_RESET));
        chk("rst_valid", 32'(validOut), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_cnt_valid", 32'(counterValid), 32'h0);
        chk("rst_data", 32'(dataOut), 32'h0);
        chk("rst_af", 32'(af), 32'h0);

        // Two words on lane 2.
        do_reset_init(1'b1, 3'd3);
        push_one(2, 12'hA01, 1'b1);
        push_one(2, 12'hA02, 1'b1);
        drain(1'b1);

        // Fresh start: lane 0 has priority, all four lanes at once, then lanes 0 and 3.
        do_reset_init(1'b0, 3'd3);
        for (int k = 0; k < 4; k++) begin
            push_v[k] = 1'b1;
            din_v[k]  = 12'((k + 1) * 12'h100);
            sb.push_back({2'(k), 12'((k + 1) * 12'h100)});
        end
        tick();
        for (int k = 0; k < 4; k++) push_v[k] = 1'b0;
        drain(1'b0);
        push_v[0] = 1'b1; din_v[0] = 12'h501;
        push_v[3] = 1'b1; din_v[3] = 12'h504;
        sb.push_back({2'd0, 12'h501});
        sb.push_back({2'd3, 12'h504});
        tick();
        push_v[0] = 1'b0;
        push_v[3] = 1'b0;
        drain(1'b1);
        rd(3'd4, 5'd6, 1'b1, "cnt_total6");
        rd(3'd0, 5'd2, 1'b1, "cnt_lane0");
        tick();
        chk("cnt_valid_drop", 32'(counterValid), 32'h0);
        chk("cnt_hold", 32'(counterOut), 32'd2);

        // Stalled lane 1 reaches threshold 3, then full, then drains in order.
        stall = 1'b1;
        push_one(1, 12'hB01, 1'b1);
        push_one(1, 12'hB02, 1'b1);
        chk("af1_occ2", 32'(almost_full1), 32'h0);
        push_one(1, 12'hB03, 1'b1);
        chk("af1_occ3", 32'(almost_full1), 32'h1);
        chk("af0_empty", 32'(almost_full0), 32'h0);
        tick();
        tick();
        chk("stall_no_valid", 32'(validOut), 32'h0);
        push_one(1, 12'hB04, 1'b1);
        chk("af1_occ4", 32'(almost_full1), 32'h1);
        chk("state_active_stalled", 32'(State), 32'(ST_ACTIVE));
        stall = 1'b0;
        drain(1'b1);

        // Overflow on lane 0: none of these words may leave.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) push_one(0, 12'(12'hD01 + i), 1'b0);
        chk("no_err_at_full", 32'(error), 32'h0);
        push_one(0, 12'hD05, 1'b0);
        chk("err_set", 32'(error), 32'h1);
        chk("state_error", 32'(State), 32'(ST_ERROR));
        stall = 1'b0;
        repeat (4) tick();
        chk("err_no_valid", 32'(validOut), 32'h0);
        rd(3'd1, 5'd5, 1'b1, "err_cnt_lane1");
        tick();
        #2 reset = 1'b0;
        #1;
        chk("async_state", 32'(State), 32'(ST_RESET));
        chk("async_error", 32'(error), 32'h0);
        chk("async_data", 32'(dataOut), 32'h0);
        chk("async_port", 32'(portOut), 32'h0);
        chk("async_cnt", 32'(counterOut), 32'h0);

        // Threshold 0 means depth; then 33 grants on lane 0 wrap the counters.
        do_reset_init(1'b0, 3'd0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) push_one(0, 12'(12'hE00 + i), 1'b1);
        chk("thr0_occ3", 32'(almost_full0), 32'h0);
        push_one(0, 12'hE03, 1'b1);
        chk("thr0_occ4", 32'(almost_full0), 32'h1);
        stall = 1'b0;
        for (int i = 0; i < 29; i++) push_one(0, 12'(12'hC00 + i), 1'b1);
        chk("full_push_pop_no_err", 32'(error), 32'h0);
        drain(1'b1);
        rd(3'd0, 5'd1, 1'b1, "cnt_lane0_wrap");
        rd(3'd4, 5'd1, 1'b1, "cnt_total_wrap");
        rd(3'd3, 5'd0, 1'b1, "cnt_lane3_zero");
        rd(3'd5, 5'd0, 1'b0, "cnt_idx5");

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
